// File: rtl/fast_keypoint_detection_mul_pipe.sv
// -----------------------------------------------------------------------------
// fast_keypoint_detection_mul_pipe
//
// Pipelined integer multiplier with valid/ready flow control and a signedness
// selection per transaction. Each operand is sign- or zero-extended to P+1 bits,
// where P = din0_WIDTH + din1_WIDTH. The exact product is registered in stage 1.
// It is then delayed through stages 2..NUM_STAGE together with its result type
// and a valid bit. The final width reduction to dout_WIDTH is combinational
// from the last stage.
//
// A single advance signal (adv = !out_valid || out_ready) moves every stage
// together. in_ready equals adv, so bubbles never block acceptance unless the
// last stage holds a result that is stalled.
//
// Build option:
//   FAST_MUL_SATURATE_EN - when defined, an overflowing result is clamped to the
//                          limit of the result type. When undefined, dout is
//                          the low dout_WIDTH bits of the product. out_ovf is
//                          flagged in both builds.
//
// Ports:
//   ap_clk      in   clock, rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   in_valid    in   input transaction valid
//   in_ready    out  input accepted this cycle (combinational from out_valid, out_ready)
//   din0        in   operand A [din0_WIDTH]
//   din1        in   operand B [din1_WIDTH]
//   in_signed0  in   1: din0 is two's complement, 0: unsigned
//   in_signed1  in   1: din1 is two's complement, 0: unsigned
//   out_valid   out  result valid
//   out_ready   in   consumer accepts the result
//   dout        out  result [dout_WIDTH]
//   out_ovf     out  result did not fit in dout_WIDTH (qualified by out_valid)
// -----------------------------------------------------------------------------
module fast_keypoint_detection_mul_pipe #(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 22,
  parameter int NUM_STAGE  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_signed0,
  input  logic                  in_signed1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  localparam int P  = din0_WIDTH + din1_WIDTH;
  localparam int PW = P + 1;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_num_stage
    $error("fast_keypoint_detection_mul_pipe: NUM_STAGE must lie in 1..8");
  end

  // ---------------------------------------------------------------------------
  // Operand extension and full product
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] mul_full;

  // P+1 bits hold every product exactly, including unsigned max times signed min.
  assign a_ext    = {{(PW-din0_WIDTH){in_signed0 & din0[din0_WIDTH-1]}}, din0};
  assign b_ext    = {{(PW-din1_WIDTH){in_signed1 & din1[din1_WIDTH-1]}}, din1};
  assign mul_full = a_ext * b_ext;

  // ---------------------------------------------------------------------------
  // Pipeline: stage 0 holds the fresh product, the remaining stages delay it
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] prod_q [NUM_STAGE];
  logic signed [PW-1:0] prod_d [NUM_STAGE];
  logic                 sgn_q  [NUM_STAGE];
  logic                 sgn_d  [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q;
  logic [NUM_STAGE-1:0] vld_d;
  logic                 adv;

  assign out_valid = vld_q[NUM_STAGE-1];
  assign adv       = !vld_q[NUM_STAGE-1] || out_ready;
  assign in_ready  = adv;

  always_comb begin
    prod_d = prod_q;
    sgn_d  = sgn_q;
    vld_d  = vld_q;
    if (adv) begin
      prod_d[0] = mul_full;
      sgn_d[0]  = in_signed0 | in_signed1;
      vld_d[0]  = in_valid;
      for (int s = 1; s < NUM_STAGE; s++) begin
        prod_d[s] = prod_q[s-1];
        sgn_d[s]  = sgn_q[s-1];
        vld_d[s]  = vld_q[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prod_q <= '{default: '0};
      sgn_q  <= '{default: 1'b0};
      vld_q  <= '0;
    end else begin
      prod_q <= prod_d;
      sgn_q  <= sgn_d;
      vld_q  <= vld_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Final width reduction (combinational from the last stage)
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] last_prod;
  logic                 last_sgn;

  assign last_prod = prod_q[NUM_STAGE-1];
  assign last_sgn  = sgn_q[NUM_STAGE-1];

  if (dout_WIDTH >= P) begin : g_wide
    // Every product fits. When dout_WIDTH == P the dropped top bit is only a
    // redundant sign copy.
    assign dout    = last_sgn ? dout_WIDTH'(last_prod) : dout_WIDTH'($unsigned(last_prod));
    assign out_ovf = 1'b0;
  end else begin : g_narrow
    logic                  ovf;
    logic [dout_WIDTH-1:0] wrap_val;

    assign wrap_val = last_prod[dout_WIDTH-1:0];

    // A signed result fits when every bit from dout_WIDTH-1 upward is a copy of
    // the sign. An unsigned result is never negative, so it fits when all bits
    // from dout_WIDTH upward are zero.
    always_comb begin
      ovf = 1'b0;
      if (last_sgn) begin
        ovf = !((&last_prod[PW-1:dout_WIDTH-1]) || !(|last_prod[PW-1:dout_WIDTH-1]));
      end else begin
        ovf = |last_prod[PW-1:dout_WIDTH];
      end
    end

    assign out_ovf = ovf;

`ifdef FAST_MUL_SATURATE_EN
    logic [dout_WIDTH-1:0] sat_min;
    logic [dout_WIDTH-1:0] sat_val;

    always_comb begin
      sat_min                = '0;
      sat_min[dout_WIDTH-1]  = 1'b1;
      sat_val                = '1;
      if (last_sgn) begin
        sat_val = last_prod[PW-1] ? sat_min : ~sat_min;
      end
    end

    assign dout = ovf ? sat_val : wrap_val;
`else
    assign dout = wrap_val;
`endif
  end

endmodule

// File: tb/tb_fast_keypoint_detection_mul_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for fast_keypoint_detection_mul_pipe.
// Four instances with different widths and depths share one stimulus stream.
// Each instance has its own out_ready handshake result and its own scoreboard.
// A single compare process runs on the falling edge. It checks out_valid,
// in_ready, dout and out_ovf against a timestamp-based reference model.
// The model follows each transaction by the number of advancing cycles since
// its acceptance. Directed transactions also carry hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fast_keypoint_detection_mul_pipe;

  localparam int NI = 4;

  function automatic int cfg_w0(input int i);
    case (i)
      3:       return 7;
      default: return 11;
    endcase
  endfunction

  function automatic int cfg_w1(input int i);
    case (i)
      3:       return 5;
      default: return 11;
    endcase
  endfunction

  function automatic int cfg_dw(input int i);
    case (i)
      0:       return 22;
      1:       return 16;
      2:       return 12;
      default: return 28;
    endcase
  endfunction

  function automatic int cfg_ns(input int i);
    case (i)
      2:       return 1;
      3:       return 8;
      default: return 3;
    endcase
  endfunction

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [10:0] din0;
  logic [10:0] din1;
  logic        sg0;
  logic        sg1;

  logic [NI-1:0] rdy_v;
  logic [NI-1:0] vld_v;
  logic [NI-1:0] ovf_v;
  logic [63:0]   dout_v [NI];

  // Literal expectations attached to the transaction presented this cycle.
  bit     lit_en [NI];
  longint lit_d  [NI];
  bit     lit_o  [NI];
  bit     final_chk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint adv_cnt [NI];
  bit     final_done = 0;

  typedef struct {
    longint d;
    bit     o;
    longint acc;
    longint cyc;
    bit     lit;
    longint ld;
    bit     lo;
  } exp_t;

  exp_t sb [NI][$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int W0 = cfg_w0(gi);
    localparam int W1 = cfg_w1(gi);
    localparam int DW = cfg_dw(gi);
    localparam int NS = cfg_ns(gi);

    logic          rdy_w;
    logic          vld_w;
    logic          ovf_w;
    logic [DW-1:0] dout_w;

    fast_keypoint_detection_mul_pipe #(
      .din0_WIDTH(W0),
      .din1_WIDTH(W1),
      .dout_WIDTH(DW),
      .NUM_STAGE (NS)
    ) u_dut (
      .ap_clk    (clk),
      .ap_rst_n  (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_w),
      .din0      (din0[W0-1:0]),
      .din1      (din1[W1-1:0]),
      .in_signed0(sg0),
      .in_signed1(sg1),
      .out_valid (vld_w),
      .out_ready (out_ready),
      .dout      (dout_w),
      .out_ovf   (ovf_w)
    );

    assign rdy_v[gi]  = rdy_w;
    assign vld_v[gi]  = vld_w;
    assign ovf_v[gi]  = ovf_w;
    assign dout_v[gi] = 64'(dout_w);
  end

  // Reference arithmetic: the exact product, then range check and reduction.
  function automatic void ref_mul(input longint a_raw, input longint b_raw,
                                  input bit s0, input bit s1, input int i,
                                  output longint d, output bit o);
    longint one;
    longint a;
    longint b;
    longint p;
    longint lo;
    longint hi;
    int     w0;
    int     w1;
    int     dw;
    bit     rs;
    one = 1;
    w0  = cfg_w0(i);
    w1  = cfg_w1(i);
    dw  = cfg_dw(i);
    a   = a_raw & ((one << w0) - 1);
    b   = b_raw & ((one << w1) - 1);
    if (s0 && ((a >> (w0 - 1)) & 1) == 1) a = a - (one << w0);
    if (s1 && ((b >> (w1 - 1)) & 1) == 1) b = b - (one << w1);
    p  = a * b;
    rs = s0 | s1;
    lo = rs ? -(one << (dw - 1)) : 0;
    hi = rs ? (one << (dw - 1)) - 1 : (one << dw) - 1;
    o  = (dw < w0 + w1) && (p < lo || p > hi);
    d  = p;
`ifdef FAST_MUL_SATURATE_EN
    if (o) d = (p < lo) ? lo : hi;
`endif
    d = d & ((one << dw) - 1);
  endfunction

  // The single compare process.
  always @(negedge clk) begin : p_check
    exp_t   e;
    bit     ev;
    longint d;
    bit     o;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        checks++;
        if (vld_v[i] !== 1'b0 || rdy_v[i] !== 1'b1 || dout_v[i] !== 64'd0 || ovf_v[i] !== 1'b0) begin
          errors++;
          $display("FAIL inst%0d reset_state: got out_valid=%b in_ready=%b dout=%0h ovf=%b, required 0 1 0 0",
                   i, vld_v[i], rdy_v[i], dout_v[i], ovf_v[i]);
        end
        sb[i].delete();
      end else begin
        ev = 1'b0;
        if (sb[i].size() > 0) begin
          e  = sb[i][0];
          ev = (adv_cnt[i] >= e.acc + longint'(cfg_ns(i)) - 1);
        end
        checks++;
        if (vld_v[i] !== ev) begin
          errors++;
          $display("FAIL inst%0d out_valid: got %b required %b at cycle %0d", i, vld_v[i], ev, cyc);
        end
        checks++;
        if (rdy_v[i] !== (!ev || out_ready)) begin
          errors++;
          $display("FAIL inst%0d in_ready: got %b required %b at cycle %0d", i, rdy_v[i], (!ev || out_ready), cyc);
        end
        if (ev) begin
          checks++;
          if (dout_v[i] !== 64'(e.d) || ovf_v[i] !== e.o) begin
            errors++;
            $display("FAIL inst%0d result: got dout=%0h ovf=%b required dout=%0h ovf=%b at cycle %0d",
                     i, dout_v[i], ovf_v[i], e.d, e.o, cyc);
          end
          if (e.lit) begin
            checks++;
            if (dout_v[i] !== 64'(e.ld) || ovf_v[i] !== e.lo) begin
              errors++;
              $display("FAIL inst%0d literal: got dout=%0h ovf=%b required dout=%0h ovf=%b",
                       i, dout_v[i], ovf_v[i], e.ld, e.lo);
            end
            checks++;
            if ((cyc - e.cyc) != longint'(cfg_ns(i))) begin
              errors++;
              $display("FAIL inst%0d latency: got %0d cycles required %0d", i, cyc - e.cyc, cfg_ns(i));
            end
          end
        end
        // Predict the coming rising edge.
        if (!ev || out_ready) begin
          if (ev) void'(sb[i].pop_front());
          adv_cnt[i]++;
          if (in_valid) begin
            ref_mul(longint'(din0), longint'(din1), sg0, sg1, i, d, o);
            e.d   = d;
            e.o   = o;
            e.acc = adv_cnt[i];
            e.cyc = cyc;
            e.lit = lit_en[i];
            e.ld  = lit_d[i];
            e.lo  = lit_o[i];
            if (lit_en[i]) begin
              checks++;
              if (d != lit_d[i] || o != lit_o[i]) begin
                errors++;
                $display("FAIL inst%0d model_pin: got dout=%0h ovf=%b required dout=%0h ovf=%b",
                         i, d, o, lit_d[i], lit_o[i]);
              end
            end
            sb[i].push_back(e);
          end
        end
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (sb[i].size() != 0) begin
          errors++;
          $display("FAIL inst%0d drain: got %0d pending results required 0", i, sb[i].size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    din0 = 11'($urandom);
    din1 = 11'($urandom);
    sg0  = 1'($urandom);
    sg1  = 1'($urandom);
  endtask

  // Sends one transaction into empty pipelines with out_ready high. Attaches
  // literal expectations for instance 0 and, optionally, instance 1.
  task automatic send_lit(input logic [10:0] a, input logic [10:0] b,
                          input bit s0, input bit s1,
                          input longint d0, input bit o0,
                          input bit en1, input longint d1, input bit o1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    din0      = a;
    din1      = b;
    sg0       = s0;
    sg1       = s1;
    lit_en[0] = 1'b1;
    lit_d[0]  = d0;
    lit_o[0]  = o0;
    lit_en[1] = en1;
    lit_d[1]  = d1;
    lit_o[1]  = o1;
    tick();
    in_valid  = 1'b0;
    lit_en[0] = 1'b0;
    lit_en[1] = 1'b0;
    repeat (10) tick();
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NI; i++) begin
      if (sb[i].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    int sent;
    int c;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din0      = '0;
    din1      = '0;
    sg0       = 1'b0;
    sg1       = 1'b0;
    final_chk = 1'b0;
    for (int i = 0; i < NI; i++) begin
      lit_en[i] = 1'b0;
      lit_d[i]  = 0;
      lit_o[i]  = 1'b0;
    end
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed operands with hand-computed results.
    send_lit(11'd2047, 11'd2047, 1'b0, 1'b0, 64'h3FF001, 1'b0, 1'b0, 0, 1'b0);
    send_lit(11'h7FF, 11'h002, 1'b1, 1'b1, 64'h3FFFFE, 1'b0, 1'b1, 64'hFFFE, 1'b0);
    send_lit(11'h7FF, 11'h7FF, 1'b0, 1'b1, 64'h3FF801, 1'b0, 1'b1, 64'hF801, 1'b0);
`ifdef FAST_MUL_SATURATE_EN
    send_lit(11'd300, 11'd300, 1'b0, 1'b0, 64'h15F90, 1'b0, 1'b1, 64'hFFFF, 1'b1);
    send_lit(11'h738, 11'h0C8, 1'b1, 1'b1, 64'h3F63C0, 1'b0, 1'b1, 64'h8000, 1'b1);
`else
    send_lit(11'd300, 11'd300, 1'b0, 1'b0, 64'h15F90, 1'b0, 1'b1, 64'h5F90, 1'b1);
    send_lit(11'h738, 11'h0C8, 1'b1, 1'b1, 64'h3F63C0, 1'b0, 1'b1, 64'h63C0, 1'b1);
`endif

    // Backpressure: five operands held until instance 0 takes each, with
    // out_ready low for four cycles in the middle.
    sent = 0;
    c    = 0;
    while ((sent < 5 || c < 9) && c < 40) begin
      in_valid  = (sent < 5);
      din0      = 11'(100 + sent * 37);
      din1      = 11'(1900 - sent * 211);
      sg0       = sent[0];
      sg1       = sent[1];
      out_ready = !(c >= 3 && c < 7);
      #1;
      if (in_valid && rdy_v[0]) sent++;
      tick();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();

    // Full-rate random stream.
    for (int k = 0; k < 200; k++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rand_ops();
      tick();
    end
    // Random valid and random backpressure.
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_ops();
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();

    // Reset with two transactions in flight. Then a transaction is accepted on
    // the first edge after release.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      rand_ops();
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    send_lit(11'd3, 11'd5, 1'b0, 1'b0, 64'hF, 1'b0, 1'b1, 64'hF, 1'b0);

    for (int k = 0; k < 60 && any_pending(); k++) tick();
    final_chk = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
